// File: rtl/nubus_pkg.sv
// nubus_pkg: shared types and constants for the NuBus slave controller.
//   state_t      - slave FSM states
//   ST_*         - status codes driven on TM during ACK (logical polarity)
//   SLOT_PREFIX  - high nibble of standard slot space (Fs000000-FsFFFFFF)
//   byte_strobe  - one-hot byte lane enable for a byte transfer
package nubus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WDATA  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] ST_DONE  = 2'b00;
  localparam logic [1:0] ST_ERR   = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;
  localparam logic [1:0] ST_RETRY = 2'b11;  // reserved, never issued

  localparam logic [3:0] SLOT_PREFIX = 4'hF;

  function automatic logic [3:0] byte_strobe(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

endpackage

// File: rtl/nubus_slave_decode.sv
// nubus_slave_decode: combinational address decode for the NuBus slave.
//   ad        in  32  address phase AD, logical polarity
//   tm0       in  1   TM0 (1 = byte transfer), logical polarity
//   id        in  4   slot ID, logical polarity
//   hit       out 1   address belongs to this card
//   super_hit out 1   hit was in super-slot space
//   addr      out 28  local byte address
//   wstrb     out 4   byte lane enables
//   size_err  out 1   unsupported size (block transfer encoding)
module nubus_slave_decode
  import nubus_pkg::*;
#(
  parameter int unsigned SUPER_EN = 1
) (
  input  logic [31:0] ad,
  input  logic        tm0,
  input  logic [3:0]  id,
  output logic        hit,
  output logic        super_hit,
  output logic [27:0] addr,
  output logic [3:0]  wstrb,
  output logic        size_err
);

  logic std_hit;
  logic sup_hit;

  always_comb begin
    std_hit = (ad[31:24] == {SLOT_PREFIX, id});
    // Slot IDs 0 and F have no super-slot region: 0 is unused and F would
    // overlap the standard slot space prefix.
    sup_hit = (SUPER_EN != 0) && (ad[31:28] == id) &&
              (id != SLOT_PREFIX) && (id != 4'h0);
    hit       = std_hit | sup_hit;
    super_hit = sup_hit;
    addr      = sup_hit ? ad[27:0] : {4'h0, ad[23:0]};

    size_err = 1'b0;
    wstrb    = 4'b0000;
    if (tm0) begin
      wstrb = byte_strobe(ad[1:0]);
    end else begin
      case (ad[1:0])
        2'b11:   wstrb = 4'b1111;
        2'b00:   wstrb = 4'b0011;
        2'b10:   wstrb = 4'b1100;
        default: size_err = 1'b1;  // 01 encodes a block transfer
      endcase
    end
  end

endmodule

// File: rtl/nubus_slave.sv
// nubus_slave: NuBus responder for the test card.
//   clkn, reset                  NuBus clock (posedge), async active-high reset
//   nub_startn/ackn/tmn/adn/idn  active-low bus inputs
//   ack_o, tm_o, tm_oe           ACK strobe and TM status (logical polarity)
//   ad_o, ad_oe                  read data (logical polarity) and enable
//   mem_*                        local access request / response
//   busy_o                       transaction in progress
//   dbg_state                    current FSM state
//
// Local handshake: mem_valid rises on entry to ACCESS and holds mem_addr,
// mem_write, mem_wstrb, mem_wdata stable until a cycle in which mem_ready=1
// (mem_rdata/mem_err are sampled in that cycle) or the wait budget expires;
// mem_valid is low in the following cycle either way.
module nubus_slave
  import nubus_pkg::*;
#(
  parameter int unsigned SUPER_EN = 1,
  parameter int unsigned MAX_WAIT = 14,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clkn,
  input  logic        reset,
  input  logic        nub_startn,
  input  logic        nub_ackn,
  input  logic [1:0]  nub_tmn,
  input  logic [31:0] nub_adn,
  input  logic [3:0]  nub_idn,
  output logic        ack_o,
  output logic [1:0]  tm_o,
  output logic        tm_oe,
  output logic [31:0] ad_o,
  output logic        ad_oe,
  output logic        mem_valid,
  output logic        mem_write,
  output logic        mem_super,
  output logic [27:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata,
  output logic        busy_o,
  output state_t      dbg_state
);

  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MAX_WAIT - 1);

  logic        start;
  logic        ack;
  logic [1:0]  tm;
  logic [31:0] ad;
  logic [3:0]  id;

  assign start = ~nub_startn;
  assign ack   = ~nub_ackn;
  assign tm    = ~nub_tmn;
  assign ad    = ~nub_adn;
  assign id    = ~nub_idn;

  logic        dec_hit;
  logic        dec_super;
  logic [27:0] dec_addr;
  logic [3:0]  dec_wstrb;
  logic        dec_size_err;

  nubus_slave_decode #(.SUPER_EN(SUPER_EN)) u_decode (
    .ad        (ad),
    .tm0       (tm[0]),
    .id        (id),
    .hit       (dec_hit),
    .super_hit (dec_super),
    .addr      (dec_addr),
    .wstrb     (dec_wstrb),
    .size_err  (dec_size_err)
  );

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  assign busy_o    = (state != S_IDLE);
  assign dbg_state = state;

  // All RESP outputs are loaded on the transition into RESP so they are
  // registered and valid for exactly the one RESP cycle.
  always_ff @(posedge clkn or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      ack_o     <= 1'b0;
      tm_o      <= 2'b00;
      tm_oe     <= 1'b0;
      ad_o      <= 32'h0;
      ad_oe     <= 1'b0;
      mem_valid <= 1'b0;
      mem_write <= 1'b0;
      mem_super <= 1'b0;
      mem_addr  <= 28'h0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          // start & ack together is an attention cycle, not a transaction.
          if (start && !ack && dec_hit) begin
            mem_addr  <= dec_addr;
            mem_super <= dec_super;
            mem_write <= ~tm[1];
            mem_wstrb <= dec_wstrb;
            if (dec_size_err) begin
              state <= S_RESP;
              ack_o <= 1'b1;
              tm_oe <= 1'b1;
              tm_o  <= ST_ERR;
              ad_oe <= tm[1];
              ad_o  <= 32'h0;
            end else if (!tm[1]) begin
              state <= S_WDATA;
            end else begin
              state     <= S_ACCESS;
              mem_valid <= 1'b1;
              wait_cnt  <= '0;
            end
          end
        end

        S_WDATA: begin
          mem_wdata <= ad;
          mem_valid <= 1'b1;
          wait_cnt  <= '0;
          state     <= S_ACCESS;
        end

        S_ACCESS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= S_RESP;
            ack_o     <= 1'b1;
            tm_oe     <= 1'b1;
            tm_o      <= mem_err ? ST_ERR : ST_DONE;
            ad_oe     <= ~mem_write;
            ad_o      <= (mem_err || mem_write) ? 32'h0 : mem_rdata;
          end else if (wait_cnt == LAST_WAIT) begin
            // This is the MAX_WAIT-th cycle without ready: give up.
            mem_valid <= 1'b0;
            state     <= S_RESP;
            ack_o     <= 1'b1;
            tm_oe     <= 1'b1;
            tm_o      <= ST_TMO;
            ad_oe     <= ~mem_write;
            ad_o      <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          ack_o <= 1'b0;
          tm_oe <= 1'b0;
          tm_o  <= 2'b00;
          ad_oe <= 1'b0;
          ad_o  <= 32'h0;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
